// File: rtl/mux_pkg.sv
// mux_pkg: shared constants and the mode encoding for the N-to-1 pipelined mux.
//   mode_e    : MODE_MANUAL (select from sel) / MODE_RR (round-robin pointer)
//   DEF_WIDTH : default per-channel data width
//   DEF_NIN   : default number of input channels
package mux_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NIN   = 4;

endpackage

// File: rtl/rr_sel_ctr.sv
// rr_sel_ctr: round-robin channel pointer for mux_nto1_pipe.
//   clkpos : clock, rising edge
//   rstn   : asynchronous active-low reset, pointer returns to 0
//   adv    : advance the pointer by one this cycle (wraps NIN-1 -> 0)
//   ptr    : current channel index
module rr_sel_ctr
  import mux_pkg::*;
#(
  parameter int NIN  = DEF_NIN,
  parameter int SELW = $clog2(NIN)
) (
  input  logic            clkpos,
  input  logic            rstn,
  input  logic            adv,
  output logic [SELW-1:0] ptr
);

  localparam logic [SELW-1:0] LAST = SELW'(NIN - 1);

  always_ff @(posedge clkpos or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (ptr == LAST) ? '0 : ptr + SELW'(1);
    end
  end

endmodule

// File: rtl/mux_nto1_pipe.sv
// mux_nto1_pipe: NIN-to-1 data multiplexer with one registered output stage
// and a valid/ready handshake on both sides.
//   clkpos    : clock, rising edge
//   rstn      : asynchronous active-low reset
//   vdd, vss  : supply pins, no logic function
//   in        : channel data, channel k at [k*WIDTH +: WIDTH]
//   sel       : channel select used in manual mode
//   mode      : 0 manual, 1 round-robin
//   in_valid  : upstream offers a word
//   in_ready  : stage can take a word this cycle
//   out       : registered selected data
//   out_valid : out holds a word
//   out_ready : downstream takes out this cycle
//   out_ch    : channel index that produced out
//   sel_err   : sticky, an out-of-range manual select was accepted
//   err_clr   : synchronous clear of sel_err (a coincident new error wins)
module mux_nto1_pipe
  import mux_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NIN   = DEF_NIN,
  localparam int SELW  = $clog2(NIN)
) (
  input  logic                 clkpos,
  input  logic                 rstn,
  input  logic                 vdd,
  input  logic                 vss,
  input  logic [NIN*WIDTH-1:0] in,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch,
  output logic                 sel_err,
  input  logic                 err_clr
);

  localparam logic [SELW:0] NIN_EXT = (SELW + 1)'(NIN);

  logic             accept;
  logic             auto_mode;
  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  eff_idx;
  logic             sel_bad;
  logic [WIDTH-1:0] sel_data;
  logic             unused_supply;

  // Supply pins are carried for cell-library compatibility only.
  assign unused_supply = vdd ^ vss;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign auto_mode = (mode_e'(mode) == MODE_RR);

  rr_sel_ctr #(
    .NIN  (NIN),
    .SELW (SELW)
  ) u_rr (
    .clkpos (clkpos),
    .rstn   (rstn),
    .adv    (accept && auto_mode),
    .ptr    (rr_ptr)
  );

  always_comb begin
    eff_idx = auto_mode ? rr_ptr : sel;
    sel_bad = !auto_mode && ({1'b0, sel} >= NIN_EXT);
  end

  // Compare against every legal index so an out-of-range sel never forms
  // an out-of-range part-select; it simply leaves sel_data at zero.
  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < NIN; k++) begin
      if (eff_idx == SELW'(k)) begin
        sel_data = in[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clkpos or negedge rstn) begin
    if (!rstn) begin
      out       <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      out       <= sel_bad ? '0 : sel_data;
      out_ch    <= eff_idx;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clkpos or negedge rstn) begin
    if (!rstn) begin
      sel_err <= 1'b0;
    end else if (accept && sel_bad) begin
      sel_err <= 1'b1;
    end else if (err_clr) begin
      sel_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// tb_mux_nto1_pipe: four instances of mux_nto1_pipe (16x4, 16x3, 8x16, 64x2)
// driven by shared stimulus and checked against a behavioural model.
module tb_mux_nto1_pipe;
  import mux_pkg::*;

  logic clkpos = 1'b0;
  always #5 clkpos = ~clkpos;

  logic          rstn, mode, in_valid, out_ready, err_clr;
  logic [1023:0] in_bus;
  logic [3:0]    sel;
  logic          vdd = 1'b1;
  logic          vss = 1'b0;

  logic [15:0] o0, o1;
  logic [7:0]  o2;
  logic [63:0] o3;
  logic [1:0]  c0, c1;
  logic [3:0]  c2;
  logic        c3;
  logic [3:0]  v, r, e;

  mux_nto1_pipe #(.WIDTH(16), .NIN(4)) d0 (
    .clkpos(clkpos), .rstn(rstn), .vdd(vdd), .vss(vss), .in(in_bus[63:0]),
    .sel(sel[1:0]), .mode(mode), .in_valid(in_valid), .in_ready(r[0]),
    .out(o0), .out_valid(v[0]), .out_ready(out_ready), .out_ch(c0),
    .sel_err(e[0]), .err_clr(err_clr));

  mux_nto1_pipe #(.WIDTH(16), .NIN(3)) d1 (
    .clkpos(clkpos), .rstn(rstn), .vdd(vdd), .vss(vss), .in(in_bus[47:0]),
    .sel(sel[1:0]), .mode(mode), .in_valid(in_valid), .in_ready(r[1]),
    .out(o1), .out_valid(v[1]), .out_ready(out_ready), .out_ch(c1),
    .sel_err(e[1]), .err_clr(err_clr));

  mux_nto1_pipe #(.WIDTH(8), .NIN(16)) d2 (
    .clkpos(clkpos), .rstn(rstn), .vdd(vdd), .vss(vss), .in(in_bus[127:0]),
    .sel(sel[3:0]), .mode(mode), .in_valid(in_valid), .in_ready(r[2]),
    .out(o2), .out_valid(v[2]), .out_ready(out_ready), .out_ch(c2),
    .sel_err(e[2]), .err_clr(err_clr));

  mux_nto1_pipe #(.WIDTH(64), .NIN(2)) d3 (
    .clkpos(clkpos), .rstn(rstn), .vdd(vdd), .vss(vss), .in(in_bus[127:0]),
    .sel(sel[0:0]), .mode(mode), .in_valid(in_valid), .in_ready(r[3]),
    .out(o3), .out_valid(v[3]), .out_ready(out_ready), .out_ch(c3),
    .sel_err(e[3]), .err_clr(err_clr));

  // Reference model: per-instance geometry and state.
  int unsigned W [4]  = '{16, 16, 8, 64};
  int unsigned N [4]  = '{4, 3, 16, 2};
  int unsigned SW [4] = '{2, 2, 4, 1};
  logic [63:0] m_out [4];
  int unsigned m_ch [4];
  int unsigned m_rr [4];
  logic        m_err [4];
  logic        m_valid;

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [63:0] dout(int i);
    case (i)
      0:       return 64'(o0);
      1:       return 64'(o1);
      2:       return 64'(o2);
      default: return o3;
    endcase
  endfunction

  function automatic logic [63:0] dch(int i);
    case (i)
      0:       return 64'(c0);
      1:       return 64'(c1);
      2:       return 64'(c2);
      default: return 64'(c3);
    endcase
  endfunction

  function automatic logic [63:0] chan(int i, int unsigned idx);
    logic [1023:0] sh;
    logic [63:0]   mask;
    sh   = in_bus >> (idx * W[i]);
    mask = (W[i] == 64) ? '1 : ((64'd1 << W[i]) - 64'd1);
    return sh[63:0] & mask;
  endfunction

  task automatic chk(input string name, input int i, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %0h expected %0h @%0t", name, i, act, exp, $time);
    end
  endtask

  task automatic check_outs();
    for (int i = 0; i < 4; i++) begin
      chk("out", i, dout(i), m_out[i]);
      chk("out_valid", i, 64'(v[i]), 64'(m_valid));
      chk("out_ch", i, dch(i), 64'(m_ch[i]));
      chk("sel_err", i, 64'(e[i]), 64'(m_err[i]));
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_out[i] = '0; m_ch[i] = 0; m_rr[i] = 0; m_err[i] = 1'b0;
    end
  endtask

  // Called just after a rising edge with inputs already set; checks in_ready,
  // advances the model, crosses the next edge and checks all outputs.
  task automatic step();
    logic        acc, bad;
    int unsigned idx;
    #1;
    for (int i = 0; i < 4; i++)
      chk("in_ready", i, 64'(r[i]), 64'(!m_valid || out_ready));
    acc = in_valid && (!m_valid || out_ready);
    for (int i = 0; i < 4; i++) begin
      idx = mode ? m_rr[i] : (int'(sel) % (1 << SW[i]));
      bad = acc && !mode && (idx >= N[i]);
      if (acc) begin
        m_out[i] = bad ? 64'd0 : chan(i, idx);
        m_ch[i]  = idx;
        if (mode) m_rr[i] = (m_rr[i] + 1) % N[i];
      end
      if (bad) m_err[i] = 1'b1;
      else if (err_clr) m_err[i] = 1'b0;
    end
    if (acc) m_valid = 1'b1;
    else if (out_ready) m_valid = 1'b0;
    @(posedge clkpos);
    #1;
    check_outs();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    model_reset();
    check_outs();
    for (int i = 0; i < 4; i++) chk("rst_in_ready", i, 64'(r[i]), 64'd1);
    @(posedge clkpos);
    #1;
    rstn = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  sel;
    logic        mode, iv, ordy, rdy;
    logic [15:0] eout;
    logic [1:0]  ech;
    logic        ev;
  } vec_t;

  vec_t        tbl [12];
  logic [15:0] held, want;

  initial begin
    tbl[0]  = '{4'd2, 1'b0, 1'b1, 1'b1, 1'b1, 16'hA002, 2'd2, 1'b1};
    tbl[1]  = '{4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 16'hA002, 2'd2, 1'b1};
    tbl[2]  = '{4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 16'hA002, 2'd2, 1'b1};
    tbl[3]  = '{4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 16'hA003, 2'd3, 1'b1};
    tbl[4]  = '{4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hA003, 2'd3, 1'b0};
    tbl[5]  = '{4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA003, 2'd3, 1'b0};
    tbl[6]  = '{4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hA000, 2'd0, 1'b1};
    tbl[7]  = '{4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hA001, 2'd1, 1'b1};
    tbl[8]  = '{4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 16'hA003, 2'd3, 1'b1};
    tbl[9]  = '{4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hA002, 2'd2, 1'b1};
    tbl[10] = '{4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hA003, 2'd3, 1'b1};
    tbl[11] = '{4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hA000, 2'd0, 1'b1};

    mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0; sel = '0;
    in_bus = '0;
    for (int k = 0; k < 64; k++) in_bus[k*16 +: 16] = 16'hA000 + 16'(k);
    do_reset();

    // Directed table on the 16x4 instance (other instances model-checked).
    for (int t = 0; t < 12; t++) begin
      sel = tbl[t].sel; mode = tbl[t].mode;
      in_valid = tbl[t].iv; out_ready = tbl[t].ordy;
      #1;
      chk("tbl_ready", t, 64'(r[0]), 64'(tbl[t].rdy));
      step();
      chk("tbl_out", t, 64'(o0), 64'(tbl[t].eout));
      chk("tbl_ch", t, 64'(c0), 64'(tbl[t].ech));
      chk("tbl_valid", t, 64'(v[0]), 64'(tbl[t].ev));
    end

    // Backpressure: three stalled cycles with changing data, then release.
    mode = 1'b0; sel = 4'd1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    held = o0;
    chk("bp_load", 0, 64'(held), 64'h0000_0000_0000_A001);
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      in_bus = {32{$urandom()}};
      sel = 4'($urandom_range(0, 3));
      step();
      chk("bp_stable", j, 64'(o0), 64'(held));
      chk("bp_ready", j, 64'(r[0]), 64'd0);
    end
    out_ready = 1'b1; sel = 4'd2;
    want = in_bus[47:32];
    step();
    chk("bp_release", 0, 64'(o0), 64'(want));

    // Reset asserted while a word is held under backpressure.
    out_ready = 1'b0; in_valid = 1'b1;
    step();
    #2;
    do_reset();
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    chk("post_rst_valid", 0, 64'(v[0]), 64'd0);

    // Round-robin with idle gaps; idle cycles must not advance the pointer.
    mode = 1'b1; out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      in_valid = 1'b1; sel = 4'($urandom_range(0, 15));
      step();
      chk("rr_ch", 0, 64'(c0), 64'(j % 4));
      chk("rr_ch", 2, 64'(c2), 64'(j));
      chk("rr_ch", 3, 64'(c3), 64'(j % 2));
      in_valid = 1'b0;
      step();
      step();
    end

    // Out-of-range select on the 3-channel instance.
    mode = 1'b0; sel = 4'd3; in_valid = 1'b1; out_ready = 1'b1;
    step();
    chk("err_out", 1, 64'(o1), 64'd0);
    chk("err_set", 1, 64'(e[1]), 64'd1);
    chk("err_none", 0, 64'(e[0]), 64'd0);
    in_valid = 1'b0;
    step();
    step();
    chk("err_sticky", 1, 64'(e[1]), 64'd1);
    err_clr = 1'b1; in_valid = 1'b1;
    step();
    chk("err_set_wins", 1, 64'(e[1]), 64'd1);
    in_valid = 1'b0;
    step();
    chk("err_clear", 1, 64'(e[1]), 64'd0);
    err_clr = 1'b0;

    // Randomised traffic against the model.
    for (int j = 0; j < 400; j++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      for (int k = 0; k < 32; k++) in_bus[k*32 +: 32] = $urandom();
      sel       = 4'($urandom_range(0, 15));
      mode      = 1'($urandom_range(0, 3) == 0);
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      err_clr   = 1'($urandom_range(0, 9) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
